// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: forwarding encodings, stage-record type and match helper for the pipeline control block
package cpu_pipe_pkg;
   localparam int PIPE_AW = 5;
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;
   typedef struct packed {
      logic               valid;
      logic [PIPE_AW-1:0] rd;
      logic [PIPE_AW-1:0] rs1;
      logic [PIPE_AW-1:0] rs2;
      logic               regwr;
      logic               memrd;
      logic               memwr;
   } stage_t;
   localparam stage_t STAGE_RST = '0;
   // x0 is hardwired to zero, so a write to it never produces a usable value
   function automatic logic match(input stage_t s, input logic [PIPE_AW-1:0] r);
      return s.valid & s.regwr & (s.rd != '0) & (s.rd == r);
   endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational stall, load-use/RAW and forwarding-select logic
module hazard_detect
   import cpu_pipe_pkg::*;
#(
   parameter int FWD_EN = 1
) (
   input  stage_t             ex,
   input  stage_t             mem,
   input  stage_t             wb,
   input  logic               id_valid,
   input  logic [PIPE_AW-1:0] id_rs1,
   input  logic [PIPE_AW-1:0] id_rs2,
   input  logic               id_rs1_used,
   input  logic               id_rs2_used,
   input  logic               dmem_ready,
   output logic               mem_stall,
   output logic               data_haz,
   output logic [1:0]         fwd_a,
   output logic [1:0]         fwd_b
);
   logic hit_ex, hit_mem;
   always_comb begin
      hit_ex    = id_valid & ((id_rs1_used & match(ex, id_rs1)) | (id_rs2_used & match(ex, id_rs2)));
      hit_mem   = id_valid & ((id_rs1_used & match(mem, id_rs1)) | (id_rs2_used & match(mem, id_rs2)));
      mem_stall = mem.valid & (mem.memrd | mem.memwr) & !dmem_ready;
      data_haz  = (FWD_EN != 0) ? (hit_ex & ex.memrd) : (hit_ex | hit_mem);
      fwd_a     = (FWD_EN == 0) ? FWD_REG :
                  (match(mem, ex.rs1) & !mem.memrd) ? FWD_MEM :
                  match(wb, ex.rs1) ? FWD_WB : FWD_REG;
      fwd_b     = (FWD_EN == 0) ? FWD_REG :
                  (match(mem, ex.rs2) & !mem.memrd) ? FWD_MEM :
                  match(wb, ex.rs2) ? FWD_WB : FWD_REG;
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stage tracking, stall/flush control and performance counters for the 5-stage pipeline
module pipe_hazard_ctrl
   import cpu_pipe_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwr,
   input  logic              id_memrd,
   input  logic              id_memwr,
   input  logic              ex_redirect,
   input  logic              dmem_ready,
   input  logic              perf_clr,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              ex_valid,
   output logic              mem_valid,
   output logic              wb_valid,
   output logic              wb_regwr_en,
   output logic [REG_AW-1:0] wb_rd,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);
   if (REG_AW != PIPE_AW) begin : g_bad_aw
      $error("REG_AW must equal cpu_pipe_pkg::PIPE_AW");
   end
   stage_t ex_q, mem_q, wb_q, id_rec;
   logic   mem_stall, data_haz, stall_inc, flush_inc;
   hazard_detect #(.FWD_EN(FWD_EN)) u_hd (
      .ex          (ex_q),
      .mem         (mem_q),
      .wb          (wb_q),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .dmem_ready  (dmem_ready),
      .mem_stall   (mem_stall),
      .data_haz    (data_haz),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b)
   );
   // a memory wait freezes everything and masks the redirect until it clears
   always_comb begin
      id_rec     = '{valid: id_valid, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
                     regwr: id_regwr, memrd: id_memrd, memwr: id_memwr};
      flush_inc  = !mem_stall & ex_redirect;
      stall_inc  = mem_stall | (!ex_redirect & data_haz);
      pc_en      = !stall_inc;
      ifid_en    = !stall_inc;
      ifid_flush = flush_inc;
      idex_flush = !mem_stall & (ex_redirect | data_haz);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q      <= STAGE_RST;
         mem_q     <= STAGE_RST;
         wb_q      <= STAGE_RST;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!mem_stall) begin
            ex_q  <= idex_flush ? STAGE_RST : id_rec;
            mem_q <= ex_q;
            wb_q  <= mem_q;
         end
         stall_cnt <= perf_clr ? '0 : (stall_inc & ~&stall_cnt) ? stall_cnt + 1'b1 : stall_cnt;
         flush_cnt <= perf_clr ? '0 : (flush_inc & ~&flush_cnt) ? flush_cnt + 1'b1 : flush_cnt;
      end
   end
   assign ex_valid    = ex_q.valid;
   assign mem_valid   = mem_q.valid;
   assign wb_valid    = wb_q.valid;
   assign wb_regwr_en = wb_q.valid & wb_q.regwr;
   assign wb_rd       = wb_q.rd;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed hazard scenarios with a WB-write scoreboard over three parameterisations
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0, rst_n = 1'b0;
   logic id_valid, id_rs1_used, id_rs2_used, id_regwr, id_memrd, id_memwr;
   logic ex_redirect, dmem_ready, perf_clr;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic pc_en, ifid_en, ifid_flush, idex_flush, ex_valid, mem_valid, wb_valid, wb_regwr_en;
   logic [4:0] wb_rd;
   logic [1:0] fwd_a, fwd_b;
   logic [15:0] stall_cnt, flush_cnt;
   logic n_pc_en, n_ifid_en, n_ifid_flush, n_idex_flush, n_ex_valid, n_mem_valid, n_wb_valid, n_wb_regwr_en;
   logic [4:0] n_wb_rd;
   logic [1:0] n_fwd_a, n_fwd_b;
   logic [15:0] n_stall_cnt, n_flush_cnt;
   logic s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush, s_ex_valid, s_mem_valid, s_wb_valid, s_wb_regwr_en;
   logic [4:0] s_wb_rd;
   logic [1:0] s_fwd_a, s_fwd_b;
   logic [3:0] s_stall_cnt, s_flush_cnt;
   int n_tests = 0, n_fail = 0;
   logic [4:0] sb_q[$];
   bit sb_on = 1'b0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_regwr(id_regwr),
      .id_memrd(id_memrd), .id_memwr(id_memwr), .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
      .perf_clr(perf_clr), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
      .wb_regwr_en(wb_regwr_en), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_hazard_ctrl #(.FWD_EN(0)) u_nf (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_regwr(id_regwr),
      .id_memrd(id_memrd), .id_memwr(id_memwr), .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
      .perf_clr(perf_clr), .pc_en(n_pc_en), .ifid_en(n_ifid_en), .ifid_flush(n_ifid_flush),
      .idex_flush(n_idex_flush), .ex_valid(n_ex_valid), .mem_valid(n_mem_valid), .wb_valid(n_wb_valid),
      .wb_regwr_en(n_wb_regwr_en), .wb_rd(n_wb_rd), .fwd_a(n_fwd_a), .fwd_b(n_fwd_b),
      .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_regwr(id_regwr),
      .id_memrd(id_memrd), .id_memwr(id_memwr), .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
      .perf_clr(perf_clr), .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
      .idex_flush(s_idex_flush), .ex_valid(s_ex_valid), .mem_valid(s_mem_valid), .wb_valid(s_wb_valid),
      .wb_regwr_en(s_wb_regwr_en), .wb_rd(s_wb_rd), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit push, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic mr, input logic mw);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
      id_rd = rd; id_regwr = wr; id_memrd = mr; id_memwr = mw;
      if (push && v && wr) sb_q.push_back(rd);
      #1;
   endtask

   task automatic nop;
      drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0; ex_redirect = 1'b0; dmem_ready = 1'b1; perf_clr = 1'b0;
      nop;
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic drain;
      nop;
      repeat (4) step;
      chk("sb_drain", sb_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (sb_on && rst_n && wb_regwr_en) begin
         if (sb_q.size() == 0) chk("sb_extra_wb", sb_q.size(), 1);
         else chk("wb_rd", wb_rd, sb_q.pop_front());
      end
   end

   initial begin
      // 1: reset state and independent back-to-back ALU ops
      sb_on = 1'b1;
      do_reset;
      #1;
      chk("rst_pc_en", pc_en, 1); chk("rst_ifid_en", ifid_en, 1);
      chk("rst_ifid_flush", ifid_flush, 0); chk("rst_idex_flush", idex_flush, 0);
      chk("rst_valids", {ex_valid, mem_valid, wb_valid, wb_regwr_en}, 0);
      chk("rst_fwd", {fwd_a, fwd_b}, 0); chk("rst_stall", stall_cnt, 0); chk("rst_flush", flush_cnt, 0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'(10 + i), 1'b1, 1'b0, 1'b0);
         chk("alu_pc_en", pc_en, 1);
         chk("alu_fwd", {fwd_a, fwd_b}, 0);
         chk("alu_wb_valid", wb_valid, (i >= 3) ? 1 : 0);
         step;
      end
      chk("alu_stall", stall_cnt, 0);
      drain;

      // 2: EX->EX forward from MEM, then from WB
      do_reset;
      drive(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      step;
      drive(1'b1, 1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      chk("fw_pc_en", pc_en, 1);
      step;
      drive(1'b1, 1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      chk("fw_mem_a", fwd_a, 2'b01); chk("fw_mem_b", fwd_b, 2'b00);
      step;
      nop;
      chk("fw_wb_a", fwd_a, 2'b10); chk("fw_wb_b", fwd_b, 2'b00);
      chk("fw_stall", stall_cnt, 0);
      drain;

      // 3: load-use costs one bubble, then forwards from WB
      do_reset;
      drive(1'b1, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
      step;
      drive(1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      chk("lu_pc_en", pc_en, 0); chk("lu_ifid_en", ifid_en, 0); chk("lu_idex_flush", idex_flush, 1);
      step;
      chk("lu_pc_en2", pc_en, 1); chk("lu_idex_flush2", idex_flush, 0); chk("lu_stall", stall_cnt, 1);
      step;
      nop;
      chk("lu_fwd_a", fwd_a, 2'b10); chk("lu_fwd_b", fwd_b, 2'b10); chk("lu_stall2", stall_cnt, 1);
      drain;

      // 4: memory wait masks a pending redirect, which then flushes
      do_reset;
      drive(1'b1, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
      step;
      drive(1'b1, 1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("br_pc_en", pc_en, 1);
      step;
      ex_redirect = 1'b1; dmem_ready = 1'b0;
      drive(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("frz_pc_en", pc_en, 0); chk("frz_ifid_en", ifid_en, 0);
         chk("frz_flushes", {ifid_flush, idex_flush}, 0); chk("frz_stall", stall_cnt, i);
         step;
      end
      dmem_ready = 1'b1;
      #1;
      chk("rd_stall", stall_cnt, 3); chk("rd_pc_en", pc_en, 1);
      chk("rd_ifid_flush", ifid_flush, 1); chk("rd_idex_flush", idex_flush, 1); chk("rd_flush0", flush_cnt, 0);
      step;
      ex_redirect = 1'b0;
      nop;
      chk("rd_flush1", flush_cnt, 1); chk("rd_ex_valid", ex_valid, 0); chk("rd_stall2", stall_cnt, 3);
      drain;

      // 5: no forwarding, RAW stalls until the producer leaves MEM; x0 never stalls
      sb_on = 1'b0;
      do_reset;
      drive(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      step;
      drive(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      chk("nf_pc_en1", n_pc_en, 0); chk("nf_idex_flush1", n_idex_flush, 1);
      step;
      chk("nf_pc_en2", n_pc_en, 0);
      step;
      chk("nf_pc_en3", n_pc_en, 1); chk("nf_fwd", {n_fwd_a, n_fwd_b}, 0); chk("nf_stall", n_stall_cnt, 2);
      step;
      drive(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      step;
      drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
      chk("nf_x0_ex", n_pc_en, 1);
      step;
      chk("nf_x0_mem", n_pc_en, 1);
      step;
      nop;
      chk("nf_stall2", n_stall_cnt, 2);

      // 6: 4-bit counter saturation, clear priority, async reset mid-stall
      do_reset;
      drive(1'b0, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
      step;
      nop;
      step;
      dmem_ready = 1'b0;
      #1;
      for (int i = 0; i < 20; i++) begin
         chk("sat_stall", s_stall_cnt, (i > 15) ? 15 : i);
         step;
      end
      chk("sat_hold", s_stall_cnt, 15);
      perf_clr = 1'b1;
      #1;
      chk("clr_stalling", s_pc_en, 0);
      step;
      perf_clr = 1'b0;
      chk("clr_stall", s_stall_cnt, 0);
      step;
      chk("clr_resume", s_stall_cnt, 1); chk("pre_rst_mem_valid", s_mem_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_mem_valid", s_mem_valid, 0); chk("arst_valids", {s_ex_valid, s_wb_valid, s_wb_regwr_en}, 0);
      chk("arst_stall", s_stall_cnt, 0); chk("arst_pc_en", s_pc_en, 1);
      dmem_ready = 1'b1;
      #2 rst_n = 1'b1;
      step;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
